// File: rtl/pattern_shift_reg.sv
// rtl/pattern_shift_reg.sv - universal shift register with pattern matcher and saturating hit counter
module pattern_shift_reg #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FILL_W  = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_n;
    logic [WIDTH-1:0]  shl;
    logic [WIDTH-1:0]  shr;
    logic              hit;

    // A hit is judged on the value q is about to take, so match lines up with q.
    always_comb begin
        shl    = {q[WIDTH-2:0], sin};
        shr    = {sin, q[WIDTH-1:1]};
        fill_n = (fill == FULL) ? FULL : fill + 1'b1;
        hit    = en && (mode == 2'b01) && (fill_n == FULL) && (shl == PATTERN);
    end

    assign sout = (mode == 2'b10) ? q[0] : q[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= hit;
            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (hit && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (en) begin
                case (mode)
                    2'b01: begin
                        q    <= shl;
                        fill <= (hit && (OVERLAP == 1'b0)) ? '0 : fill_n;
                    end
                    2'b10: begin
                        q    <= shr;
                        fill <= '0;
                    end
                    2'b11: begin
                        q    <= d;
                        fill <= FULL;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_shift_reg.sv
// tb/tb_pattern_shift_reg.sv - scoreboard bench for pattern_shift_reg (overlap, non-overlap, narrow counter)
module tb_pattern_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       sin = 1'b0;
    logic [3:0] d = 4'b0000;
    logic       cnt_clr = 1'b0;

    logic [3:0] q0, q1, q2;
    logic       s0, s1, s2;
    logic       m0, m1, m2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    always #5 clk = ~clk;

    pattern_shift_reg u_ovl (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .d(d), .cnt_clr(cnt_clr),
        .q(q0), .sout(s0), .match(m0), .match_cnt(c0)
    );

    pattern_shift_reg #(.OVERLAP(1'b0)) u_novl (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .d(d), .cnt_clr(cnt_clr),
        .q(q1), .sout(s1), .match(m1), .match_cnt(c1)
    );

    pattern_shift_reg #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .d(d), .cnt_clr(cnt_clr),
        .q(q2), .sout(s2), .match(m2), .match_cnt(c2)
    );

    typedef struct {
        int         id;
        logic [3:0] q;
        logic       m;
        logic [7:0] c;
        logic       s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] q_a [3];
    logic       s_a [3];
    logic       m_a [3];
    logic [7:0] c_a [3];
    assign q_a[0] = q0; assign q_a[1] = q1; assign q_a[2] = q2;
    assign s_a[0] = s0; assign s_a[1] = s1; assign s_a[2] = s2;
    assign m_a[0] = m0; assign m_a[1] = m1; assign m_a[2] = m2;
    assign c_a[0] = c0; assign c_a[1] = c1; assign c_a[2] = {6'b0, c2};

    task automatic cmp(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d entry%0d actual %0h required %0h", name, id, checks, act, exp);
        end
    endtask

    // Monitor: one expected entry per sampled cycle; id 3 means every instance.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                if (e.id == i || e.id == 3) begin
                    cmp("q",     i, {4'b0, q_a[i]}, {4'b0, e.q});
                    cmp("match", i, {7'b0, m_a[i]}, {7'b0, e.m});
                    cmp("cnt",   i, c_a[i],         e.c);
                    cmp("sout",  i, {7'b0, s_a[i]}, {7'b0, e.s});
                end
            end
        end
    end

    task automatic step(input logic e_en, input logic [1:0] md, input logic s, input logic [3:0] dd,
                        input logic clr, input int id, input logic [3:0] eq, input logic em,
                        input logic [7:0] ec, input logic es);
        exp_t e;
        @(negedge clk);
        #1;
        en = e_en; mode = md; sin = s; d = dd; cnt_clr = clr;
        @(posedge clk);
        e = '{id, eq, em, ec, es};
        sb.push_back(e);
    endtask

    task automatic sl(input logic s, input int id, input logic [3:0] eq, input logic em, input logic [7:0] ec);
        step(1'b1, 2'b01, s, 4'b0000, 1'b0, id, eq, em, ec, eq[3]);
    endtask

    task automatic sr(input logic s, input int id, input logic [3:0] eq, input logic em, input logic [7:0] ec);
        step(1'b1, 2'b10, s, 4'b0000, 1'b0, id, eq, em, ec, eq[0]);
    endtask

    // Short reset pulse that never spans a clock edge, so only an async reset clears state.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #1;
        en = 1'b0; mode = 2'b00; sin = 1'b0; d = 4'b0000; cnt_clr = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        e = '{3, 4'b0000, 1'b0, 8'd0, 1'b0};
        sb.push_back(e);
    endtask

    initial begin
        do_reset();
        sl(1, 0, 4'b0001, 0, 0); sl(0, 0, 4'b0010, 0, 0); sl(1, 0, 4'b0101, 0, 0);
        sl(1, 0, 4'b1011, 1, 1); sl(0, 0, 4'b0110, 0, 1); sl(1, 0, 4'b1101, 0, 1);
        sl(1, 0, 4'b1011, 1, 2);

        do_reset();
        sl(1, 1, 4'b0001, 0, 0); sl(0, 1, 4'b0010, 0, 0); sl(1, 1, 4'b0101, 0, 0);
        sl(1, 1, 4'b1011, 1, 1); sl(0, 1, 4'b0110, 0, 1); sl(1, 1, 4'b1101, 0, 1);
        sl(1, 1, 4'b1011, 0, 1); sl(1, 1, 4'b0111, 0, 1); sl(0, 1, 4'b1110, 0, 1);
        sl(1, 1, 4'b1101, 0, 1); sl(1, 1, 4'b1011, 1, 2);

        do_reset();
        step(1'b1, 2'b11, 1'b0, 4'b1011, 1'b0, 0, 4'b1011, 0, 0, 1'b1);
        sl(1, 0, 4'b0111, 0, 0); sl(0, 0, 4'b1110, 0, 0); sl(1, 0, 4'b1101, 0, 0);
        sl(1, 0, 4'b1011, 1, 1);

        do_reset();
        step(1'b1, 2'b11, 1'b0, 4'b0000, 1'b0, 0, 4'b0000, 0, 0, 1'b0);
        sr(1, 0, 4'b1000, 0, 0); sr(1, 0, 4'b1100, 0, 0); sr(1, 0, 4'b1110, 0, 0);
        sr(1, 0, 4'b1111, 0, 0);
        step(1'b0, 2'b11, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 0, 0, 1'b1);
        step(1'b0, 2'b01, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 0, 0, 1'b1);
        step(1'b0, 2'b10, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 0, 0, 1'b1);
        sl(0, 0, 4'b1110, 0, 0); sl(1, 0, 4'b1101, 0, 0); sl(1, 0, 4'b1011, 0, 0);

        do_reset();
        sl(1, 2, 4'b0001, 0, 0); sl(0, 2, 4'b0010, 0, 0); sl(1, 2, 4'b0101, 0, 0);
        sl(1, 2, 4'b1011, 1, 1);
        for (int k = 2; k <= 5; k++) begin
            sl(0, 2, 4'b0110, 0, 8'((k - 1 > 3) ? 3 : k - 1));
            sl(1, 2, 4'b1101, 0, 8'((k - 1 > 3) ? 3 : k - 1));
            sl(1, 2, 4'b1011, 1, 8'((k > 3) ? 3 : k));
        end
        sl(0, 2, 4'b0110, 0, 3); sl(1, 2, 4'b1101, 0, 3);
        step(1'b1, 2'b01, 1'b1, 4'b0000, 1'b1, 2, 4'b1011, 1, 0, 1'b1);

        do_reset();
        sl(1, 0, 4'b0001, 0, 0); sl(0, 0, 4'b0010, 0, 0); sl(1, 0, 4'b0101, 0, 0);
        do_reset();
        sl(1, 0, 4'b0001, 0, 0); sl(1, 0, 4'b0011, 0, 0); sl(0, 0, 4'b0110, 0, 0);
        sl(1, 0, 4'b1101, 0, 0); sl(1, 0, 4'b1011, 1, 1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
